soc_led_pio_arbiter: RTL and testbench

- Shares the 10-bit LED PIO slave between two requesters: the HPS-side control bridge (req0) and the ADSR envelope level meter (req1).
- Grants requesters round-robin and drives the PIO's Avalon-MM slave port as its only master.
- Performs each write as write-then-readback, raises a sticky error when the readback does not match, and keeps a shadow copy of the committed LED pattern.

---
 rtl/soc_led_pio_arbiter_if.sv | 46 ++++
 rtl/soc_led_pio_arbiter.sv | 149 ++++++++++++++
 tb/tb_soc_led_pio_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/soc_led_pio_arbiter_if.sv
// ---------------------------------------------------------------------------
// soc_led_pio_arbiter_if
// Bundles the two requester handshakes, the Avalon-MM PIO slave port and the
// status/control signals of soc_led_pio_arbiter.
//   master : arbiter side (drives acks, PIO bus and status)
//   slave  : environment side (requesters, PIO, error clear)
// Signals:
//   req0_valid/req0_data/req0_ack  requester 0 (HPS control bridge)
//   req1_valid/req1_data/req1_ack  requester 1 (ADSR level meter)
//   pio_address/pio_chipselect/pio_write_n/pio_writedata/pio_readdata
//   led_shadow  last committed pattern
//   busy        transaction in flight
//   verify_err  sticky readback mismatch
//   err_clr     clears verify_err
// ---------------------------------------------------------------------------
interface soc_led_pio_arbiter_if #(
  parameter int LED_WIDTH = 10
);
  logic                 req0_valid;
  logic [LED_WIDTH-1:0] req0_data;
  logic                 req0_ack;
  logic                 req1_valid;
  logic [LED_WIDTH-1:0] req1_data;
  logic                 req1_ack;
  logic [1:0]           pio_address;
  logic                 pio_chipselect;
  logic                 pio_write_n;
  logic [31:0]          pio_writedata;
  logic [31:0]          pio_readdata;
  logic [LED_WIDTH-1:0] led_shadow;
  logic                 busy;
  logic                 verify_err;
  logic                 err_clr;

  modport master (
    input  req0_valid, req0_data, req1_valid, req1_data, pio_readdata, err_clr,
    output req0_ack, req1_ack, pio_address, pio_chipselect, pio_write_n,
           pio_writedata, led_shadow, busy, verify_err
  );

  modport slave (
    output req0_valid, req0_data, req1_valid, req1_data, pio_readdata, err_clr,
    input  req0_ack, req1_ack, pio_address, pio_chipselect, pio_write_n,
           pio_writedata, led_shadow, busy, verify_err
  );
endinterface

// File: rtl/soc_led_pio_arbiter.sv
// ---------------------------------------------------------------------------
// soc_led_pio_arbiter
// Round-robin arbiter sharing the LED PIO slave between two requesters. Every
// write is performed as write-then-readback; a mismatch raises a sticky
// verify_err. A shadow of the last committed pattern is kept.
// Ports:
//   clk    system clock
//   reset  asynchronous active-high reset
//   bus    soc_led_pio_arbiter_if.master (requesters, PIO port, status)
// Transaction timing: grant edge -> WR cycle -> RD cycle -> ACK cycle -> IDLE.
// ---------------------------------------------------------------------------
module soc_led_pio_arbiter #(
  parameter int                   LED_WIDTH = 10,
  parameter logic [1:0]           PIO_ADDR  = 2'd0,
  parameter logic [LED_WIDTH-1:0] LED_RESET = {LED_WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  reset,
  soc_led_pio_arbiter_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_ACK} state_t;

  state_t               r_state, w_state_next;

  logic                 r_last_grant, r_grant;
  logic [LED_WIDTH-1:0] r_wdata, r_rdback, r_shadow;
  logic                 r_cs, r_wn, r_ack0, r_ack1, r_busy, r_err;
  logic [1:0]           r_addr;
  logic [31:0]          r_wrdata;

  logic                 w_req_any, w_grant_idx, w_do_grant;
  logic [LED_WIDTH-1:0] w_grant_data;

  logic                 w_last_grant_next, w_grant_next;
  logic [LED_WIDTH-1:0] w_wdata_next, w_rdback_next, w_shadow_next;
  logic                 w_cs_next, w_wn_next, w_ack0_next, w_ack1_next;
  logic                 w_busy_next, w_err_next;
  logic [1:0]           w_addr_next;
  logic [31:0]          w_wrdata_next;

  // Upper readdata bits are never meaningful for an LED_WIDTH-bit PIO.
  logic                 w_rd_unused;
  assign w_rd_unused = ^bus.pio_readdata[31:LED_WIDTH];

  // Arbitration: a lone requester wins outright; on contention the one that
  // did not win last time is chosen.
  assign w_req_any    = bus.req0_valid | bus.req1_valid;
  assign w_grant_idx  = (bus.req0_valid & bus.req1_valid) ? ~r_last_grant
                                                          : bus.req1_valid;
  assign w_grant_data = w_grant_idx ? bus.req1_data : bus.req0_data;
  assign w_do_grant   = (r_state == S_IDLE) && w_req_any;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_req_any) w_state_next = S_WR;
      S_WR:    w_state_next = S_RD;
      S_RD:    w_state_next = S_ACK;
      S_ACK:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs and datapath,
  // decoded from the state being entered so every output is registered.
  always_comb begin
    w_last_grant_next = r_last_grant;
    w_grant_next      = r_grant;
    w_wdata_next      = r_wdata;
    w_wrdata_next     = r_wrdata;
    w_addr_next       = r_addr;
    if (w_do_grant) begin
      w_last_grant_next = w_grant_idx;
      w_grant_next      = w_grant_idx;
      w_wdata_next      = w_grant_data;
      w_wrdata_next     = '0;
      w_wrdata_next[LED_WIDTH-1:0] = w_grant_data;
      w_addr_next       = PIO_ADDR;
    end

    w_cs_next   = (w_state_next == S_WR) || (w_state_next == S_RD);
    w_wn_next   = (w_state_next != S_WR);
    w_ack0_next = (w_state_next == S_ACK) && !r_grant;
    w_ack1_next = (w_state_next == S_ACK) &&  r_grant;
    w_busy_next = (w_state_next != S_IDLE);

    // Readback is sampled at the end of RD; the PIO register already holds
    // the value written on the WR edge. The shadow commits with the ack.
    w_rdback_next = (r_state == S_RD) ? bus.pio_readdata[LED_WIDTH-1:0] : r_rdback;
    w_shadow_next = (r_state == S_RD) ? r_wdata : r_shadow;

    // A mismatch in the ACK cycle outranks a simultaneous clear.
    if ((r_state == S_ACK) && (r_rdback != r_wdata)) w_err_next = 1'b1;
    else if (bus.err_clr)                            w_err_next = 1'b0;
    else                                             w_err_next = r_err;
  end

  // Output and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_wdata      <= '0;
      r_rdback     <= '0;
      r_shadow     <= LED_RESET;
      r_cs         <= 1'b0;
      r_wn         <= 1'b1;
      r_addr       <= 2'd0;
      r_wrdata     <= '0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_last_grant <= w_last_grant_next;
      r_grant      <= w_grant_next;
      r_wdata      <= w_wdata_next;
      r_rdback     <= w_rdback_next;
      r_shadow     <= w_shadow_next;
      r_cs         <= w_cs_next;
      r_wn         <= w_wn_next;
      r_addr       <= w_addr_next;
      r_wrdata     <= w_wrdata_next;
      r_ack0       <= w_ack0_next;
      r_ack1       <= w_ack1_next;
      r_busy       <= w_busy_next;
      r_err        <= w_err_next;
    end
  end

  assign bus.pio_chipselect = r_cs;
  assign bus.pio_write_n    = r_wn;
  assign bus.pio_address    = r_addr;
  assign bus.pio_writedata  = r_wrdata;
  assign bus.req0_ack       = r_ack0;
  assign bus.req1_ack       = r_ack1;
  assign bus.led_shadow     = r_shadow;
  assign bus.busy           = r_busy;
  assign bus.verify_err     = r_err;

endmodule

// File: tb/tb_soc_led_pio_arbiter.sv
// ---------------------------------------------------------------------------
// tb_soc_led_pio_arbiter
// Directed bench for soc_led_pio_arbiter with an attached PIO model, a
// transaction-level reference model checked every cycle, and hand-computed
// literal expectations for each scenario.
// ---------------------------------------------------------------------------
module tb_soc_led_pio_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  soc_led_pio_arbiter_if #(.LED_WIDTH(10)) bus ();

  soc_led_pio_arbiter #(
    .LED_WIDTH(10),
    .PIO_ADDR (2'd0),
    .LED_RESET(10'h3FF)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // PIO slave: one data register, reset to all ones, readdata combinational.
  logic [9:0] pio_out;
  logic       force_rd = 1'b0;
  always @(posedge clk or posedge reset) begin
    if (reset) pio_out <= 10'h3FF;
    else if (bus.pio_chipselect && !bus.pio_write_n && bus.pio_address == 2'd0)
      pio_out <= bus.pio_writedata[9:0];
  end
  assign bus.pio_readdata = force_rd ? 32'h0000_03FF : {22'd0, pio_out};

  // Reference model: m_phase counts cycles since the grant (0 = idle);
  // cycle 1 writes, cycle 2 reads back, cycle 3 acknowledges.
  logic [1:0] m_phase;
  logic       m_who, m_last, m_err;
  logic [9:0] m_data, m_rb, m_shadow;
  logic       m_pick;
  assign m_pick = (bus.req0_valid && bus.req1_valid) ? !m_last : bus.req1_valid;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase  <= 2'd0;
      m_who    <= 1'b0;
      m_last   <= 1'b1;
      m_err    <= 1'b0;
      m_data   <= 10'd0;
      m_rb     <= 10'd0;
      m_shadow <= 10'h3FF;
    end else begin
      if (m_phase == 2'd3 && m_rb != m_data) m_err <= 1'b1;
      else if (bus.err_clr)                  m_err <= 1'b0;
      if (m_phase == 2'd0) begin
        if (bus.req0_valid || bus.req1_valid) begin
          m_who   <= m_pick;
          m_last  <= m_pick;
          m_data  <= m_pick ? bus.req1_data : bus.req0_data;
          m_phase <= 2'd1;
        end
      end else if (m_phase == 2'd2) begin
        m_rb     <= bus.pio_readdata[9:0];
        m_shadow <= m_data;
        m_phase  <= 2'd3;
      end else if (m_phase == 2'd3) begin
        m_phase <= 2'd0;
      end else begin
        m_phase <= 2'd2;
      end
    end
  end

  // Per-cycle comparison against the model, one line per committed write.
  always @(negedge clk) begin
    chk("cs",     32'(bus.pio_chipselect), 32'(m_phase == 2'd1 || m_phase == 2'd2));
    chk("write_n",32'(bus.pio_write_n),    32'(m_phase != 2'd1));
    chk("addr",   32'(bus.pio_address),    32'd0);
    if (m_phase == 2'd1) chk("wdata", bus.pio_writedata, {22'd0, m_data});
    chk("ack0",   32'(bus.req0_ack),       32'(m_phase == 2'd3 && !m_who));
    chk("ack1",   32'(bus.req1_ack),       32'(m_phase == 2'd3 &&  m_who));
    chk("busy",   32'(bus.busy),           32'(m_phase != 2'd0));
    chk("shadow", 32'(bus.led_shadow),     32'(m_shadow));
    chk("verr",   32'(bus.verify_err),     32'(m_err));
    if (bus.req0_ack || bus.req1_ack)
      $display("txn: ack req%0d shadow=0x%03h verify_err=%0d pio=0x%03h",
               bus.req1_ack ? 1 : 0, bus.led_shadow, bus.verify_err, pio_out);
  end

  task automatic wait_ack(input int who, input string name);
    int n = 0;
    logic a;
    do begin
      @(negedge clk);
      n++;
      a = (who == 0) ? bus.req0_ack : bus.req1_ack;
    end while (!a && n < 20);
    chk(name, 32'(a), 32'd1);
  endtask

  task automatic do_write(input int who, input logic [9:0] d, input string name);
    @(negedge clk);
    if (who == 0) begin bus.req0_valid = 1'b1; bus.req0_data = d; end
    else          begin bus.req1_valid = 1'b1; bus.req1_data = d; end
    wait_ack(who, name);
    if (who == 0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int prev, cur, nacks;
    bus.req0_valid = 1'b0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_data = '0;
    bus.err_clr    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs",     32'(bus.pio_chipselect), 32'd0);
    chk("rst_wn",     32'(bus.pio_write_n),    32'd1);
    chk("rst_shadow", 32'(bus.led_shadow),     32'h3FF);
    #2 reset = 1'b0;

    // Contention right after reset: req0 first, then req1.
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_data = 10'h0F0;
    bus.req1_valid = 1'b1; bus.req1_data = 10'h30F;
    repeat (3) @(negedge clk);
    chk("cont_ack0_t3", 32'(bus.req0_ack), 32'd1);
    chk("cont_ack1_t3", 32'(bus.req1_ack), 32'd0);
    bus.req0_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("cont_ack1_t7", 32'(bus.req1_ack), 32'd1);
    bus.req1_valid = 1'b0;
    @(negedge clk);
    chk("cont_pio",    32'(pio_out),        32'h30F);
    chk("cont_shadow", 32'(bus.led_shadow), 32'h30F);

    // Single write with cycle-exact expectations.
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_data = 10'h155;
    @(negedge clk);
    chk("single_wr_data", bus.pio_writedata, 32'h0000_0155);
    chk("single_wr_cs",   32'(bus.pio_chipselect), 32'd1);
    chk("single_wr_wn",   32'(bus.pio_write_n),    32'd0);
    bus.req0_data = 10'h2AA; // ignored after grant
    @(negedge clk);
    chk("single_rd_wn",   32'(bus.pio_write_n),    32'd1);
    @(negedge clk);
    chk("single_ack",     32'(bus.req0_ack),       32'd1);
    chk("single_shadow",  32'(bus.led_shadow),     32'h155);
    bus.req0_valid = 1'b0;
    @(negedge clk);
    chk("single_idle",    32'(bus.busy),           32'd0);
    chk("single_verr",    32'(bus.verify_err),     32'd0);
    chk("single_pio",     32'(pio_out),            32'h155);

    // Fairness: both held for 40 cycles.
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_data = 10'h00F;
    bus.req1_valid = 1'b1; bus.req1_data = 10'h3C0;
    prev = 0; nacks = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.req0_ack || bus.req1_ack) begin
        cur = bus.req1_ack ? 1 : 0;
        if (nacks > 0) chk("fair_alternate", 32'(cur), 32'(1 - prev));
        prev = cur;
        nacks++;
      end
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    chk("fair_count", 32'(nacks), 32'd10);

    // Mismatch, stickiness, clear, and clear-vs-set.
    @(negedge clk);
    force_rd = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_data = 10'h001;
    wait_ack(0, "mm_ack");
    bus.req0_valid = 1'b0; force_rd = 1'b0;
    @(negedge clk);
    chk("mm_verr_set", 32'(bus.verify_err), 32'd1);
    do_write(1, 10'h2AA, "mm_good_ack");
    @(negedge clk);
    chk("mm_verr_sticky", 32'(bus.verify_err), 32'd1);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    chk("mm_verr_clr", 32'(bus.verify_err), 32'd0);
    @(negedge clk);
    force_rd = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_data = 10'h002;
    wait_ack(0, "mm2_ack");
    bus.err_clr = 1'b1; bus.req0_valid = 1'b0; force_rd = 1'b0;
    @(negedge clk);
    bus.err_clr = 1'b0;
    chk("mm_set_wins", 32'(bus.verify_err), 32'd1);

    // Reset during WR: no ack, shadow restored, held valid re-granted.
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_data = 10'h0AA;
    @(negedge clk);
    chk("rwr_in_wr", 32'(bus.pio_write_n), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("rwr_cs",     32'(bus.pio_chipselect), 32'd0);
    chk("rwr_wn",     32'(bus.pio_write_n),    32'd1);
    chk("rwr_busy",   32'(bus.busy),           32'd0);
    chk("rwr_verr",   32'(bus.verify_err),     32'd0);
    chk("rwr_shadow", 32'(bus.led_shadow),     32'h3FF);
    repeat (2) @(negedge clk);
    chk("rwr_no_ack", 32'(bus.req0_ack),       32'd0);
    #2 reset = 1'b0;
    wait_ack(0, "rwr_regrant");
    chk("rwr_shadow2", 32'(bus.led_shadow), 32'h0AA);
    bus.req0_valid = 1'b0;
    @(negedge clk);
    chk("rwr_pio", 32'(pio_out), 32'h0AA);

    // Last winner was req0; a reset must make req0 win contention again.
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("rst2_shadow", 32'(bus.led_shadow), 32'h3FF);
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_data = 10'h111;
    bus.req1_valid = 1'b1; bus.req1_data = 10'h222;
    repeat (3) @(negedge clk);
    chk("rst2_ack0", 32'(bus.req0_ack), 32'd1);
    chk("rst2_ack1", 32'(bus.req1_ack), 32'd0);
    bus.req0_valid = 1'b0;
    wait_ack(1, "rst2_req1_ack");
    bus.req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst2_pio", 32'(pio_out), 32'h222);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
